ifetch_stage: RTL and testbench

//  Instruction fetch stage upstream of the IF/ID register. Owns the PC and issues one 32-bit

---
 rtl/ifetch_stage.sv | 113 +++++++++++
 tb/tb_ifetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one fetch in flight to instruction memory,
// and presents {inst_o, pc_o} to IF/ID with NOP bubbles, stall hold and redirect/kill.
module ifetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        valid_o,
  output logic [63:0] inst_count_o,
  output logic [1:0]  state_o
);

  // Memory handshake: imem_req_o is a one-cycle pulse that memory always accepts; exactly
  // one imem_rvalid_i pulse answers it at least one cycle later. At most one is in flight.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        kill_q;
  logic [31:0] inst_q;
  logic [63:0] pc_out_q;
  logic        valid_q;
  logic [63:0] count_q;

  logic [63:0] redirect_tgt;
  logic        unused_low_bits;

  assign redirect_tgt    = {redirect_pc_i[63:2], 2'b00};
  assign unused_low_bits = ^redirect_pc_i[1:0];

  // A redirect in S_REQ suppresses the fetch so the wrong-path address never goes out.
  assign imem_req_o   = (state_q == S_REQ) && !redirect_i && !reset;
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_out_q;
  assign valid_o      = valid_q;
  assign inst_count_o = count_q;
  assign state_o      = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      inst_q   <= NOP_INST;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
      count_q  <= 64'd0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (redirect_i) begin
            pc_q <= redirect_tgt;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (!kill_q && !redirect_i) begin
              inst_q   <= imem_rdata_i;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              state_q  <= S_VALID;
            end else begin
              // Stale response for a redirected fetch: drop it and refetch from pc_q.
              kill_q  <= 1'b0;
              state_q <= S_REQ;
              if (redirect_i) begin
                pc_q <= redirect_tgt;
              end
            end
          end else if (redirect_i) begin
            pc_q   <= redirect_tgt;
            kill_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (redirect_i) begin
            pc_q    <= redirect_tgt;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end else if (!stall_i) begin
            pc_q    <= pc_q + 64'd4;
            count_q <= count_q + 64'd1;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: a variable-latency memory responder plus a linear
// sequence of steps with hand-computed expectations for fetch, stall, redirect and reset.
module tb_ifetch_stage;

  logic        clock;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        valid_o;
  logic [63:0] inst_count_o;
  logic [1:0]  state_o;

  int checks;
  int errors;

  // memory responder controls
  int          lat;
  int          cnt;
  logic [31:0] mem_data;
  logic        rv_m;
  logic [31:0] rd_m;
  logic        force_rv;

  localparam logic [31:0] NOP = 32'h0000_0013;

  ifetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .inst_count_o  (inst_count_o),
    .state_o       (state_o)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign imem_rvalid_i = rv_m | force_rv;
  assign imem_rdata_i  = rd_m;

  // Responds lat cycles after a request; runs on the falling edge, away from DUT sampling.
  always @(negedge clock) begin
    rv_m = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        rv_m = 1'b1;
        rd_m = mem_data;
      end
    end
    if (imem_req_o) cnt = lat;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    lat = 1; cnt = 0; mem_data = 32'h0010_0093; rv_m = 1'b0; rd_m = 32'h0; force_rv = 1'b0;
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 64'h0;

    // reset state
    step(); step();
    check("rst_valid", valid_o, 0);
    check("rst_inst", inst_o, NOP);
    check("rst_pc", pc_o, 64'h8000_0000);
    check("rst_count", inst_count_o, 0);
    check("rst_req", imem_req_o, 0);
    check("rst_state", state_o, 0);

    // 1: first fetch, latency 1
    reset = 1'b0; #1;
    check("t1_req", imem_req_o, 1);
    check("t1_addr", imem_addr_o, 64'h8000_0000);
    step();
    check("t1_wait_valid", valid_o, 0);
    check("t1_wait_req", imem_req_o, 0);
    check("t1_wait_state", state_o, 1);
    step();
    check("t1_valid", valid_o, 1);
    check("t1_inst", inst_o, 32'h0010_0093);
    check("t1_pc", pc_o, 64'h8000_0000);
    step();
    check("t1_req2", imem_req_o, 1);
    check("t1_addr2", imem_addr_o, 64'h8000_0004);
    check("t1_count", inst_count_o, 1);
    check("t1_bubble_valid", valid_o, 0);
    check("t1_bubble_inst", inst_o, NOP);
    mem_data = 32'h0020_0113;

    // 2: stall for three cycles in S_VALID
    step(); step();
    check("t2_valid", valid_o, 1);
    check("t2_inst", inst_o, 32'h0020_0113);
    check("t2_pc", pc_o, 64'h8000_0004);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_valid", valid_o, 1);
      check("t2_hold_inst", inst_o, 32'h0020_0113);
      check("t2_hold_pc", pc_o, 64'h8000_0004);
      check("t2_hold_req", imem_req_o, 0);
      check("t2_hold_count", inst_count_o, 1);
    end
    stall_i = 1'b0;
    lat = 4;
    step();
    check("t2_count", inst_count_o, 2);
    check("t2_req", imem_req_o, 1);
    check("t2_addr", imem_addr_o, 64'h8000_0008);

    // 3: latency 4, redirect one cycle after the request
    step();
    mem_data = 32'hDEAD_BEEF;
    redirect_i = 1'b1; redirect_pc_i = 64'h8000_0100; #1;
    check("t3_redir_req", imem_req_o, 0);
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_kill_valid", valid_o, 0);
      check("t3_kill_req", imem_req_o, 0);
      step();
    end
    check("t3_req", imem_req_o, 1);
    check("t3_addr", imem_addr_o, 64'h8000_0100);
    check("t3_req_valid", valid_o, 0);
    mem_data = 32'h0030_0193;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_wait_valid", valid_o, 0);
    end
    step();
    check("t3_valid", valid_o, 1);
    check("t3_pc", pc_o, 64'h8000_0100);
    check("t3_inst", inst_o, 32'h0030_0193);

    // 4: redirect and stall together in S_VALID
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 64'h8000_0200;
    lat = 1;
    step();
    stall_i = 1'b0; redirect_i = 1'b0; #1;
    check("t4_req", imem_req_o, 1);
    check("t4_addr", imem_addr_o, 64'h8000_0200);
    check("t4_count", inst_count_o, 2);
    check("t4_valid", valid_o, 0);
    mem_data = 32'h0040_0213;
    step(); step();
    check("t4_valid2", valid_o, 1);
    check("t4_pc2", pc_o, 64'h8000_0200);
    check("t4_inst2", inst_o, 32'h0040_0213);
    step();
    check("t4_count2", inst_count_o, 3);

    // 5: redirect in S_REQ, low address bits ignored
    redirect_i = 1'b1; redirect_pc_i = 64'h0000_0000_0000_1237; #1;
    check("t5_req_off", imem_req_o, 0);
    step();
    redirect_i = 1'b0; #1;
    check("t5_req", imem_req_o, 1);
    check("t5_addr", imem_addr_o, 64'h0000_0000_0000_1234);
    mem_data = 32'h0050_0293;
    step(); step();
    check("t5_valid", valid_o, 1);
    check("t5_pc", pc_o, 64'h0000_0000_0000_1234);
    lat = 3;

    // 6: reset during S_WAIT with a response arriving under reset
    step();
    check("t6_req", imem_req_o, 1);
    check("t6_addr", imem_addr_o, 64'h0000_0000_0000_1238);
    check("t6_count", inst_count_o, 4);
    step();
    reset = 1'b1;
    step();
    force_rv = 1'b1;
    check("t6_rst_valid", valid_o, 0);
    check("t6_rst_pc", pc_o, 64'h8000_0000);
    check("t6_rst_count", inst_count_o, 0);
    check("t6_rst_req", imem_req_o, 0);
    step();
    check("t6_rst_valid2", valid_o, 0);
    check("t6_rst_inst", inst_o, NOP);
    step();
    force_rv = 1'b0;
    lat = 1; mem_data = 32'h0060_0313;
    reset = 1'b0; #1;
    check("t6_rel_req", imem_req_o, 1);
    check("t6_rel_addr", imem_addr_o, 64'h8000_0000);
    check("t6_rel_valid", valid_o, 0);
    step(); step();
    check("t6_valid", valid_o, 1);
    check("t6_pc", pc_o, 64'h8000_0000);
    check("t6_inst", inst_o, 32'h0060_0313);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
